// File: rtl/bster_pkg.sv
// bster_pkg: shared width defaults and channel-index width helper for bster blocks.
package bster_pkg;
  localparam int AXI4S_WIDTH_DEF = 128;
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/bster_tag_fifo.sv
// bster_tag_fifo: register-array FIFO with wrap pointers carrying an extra MSB for full/empty.
module bster_tag_fifo #(
  parameter int W = 2,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr, rptr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
    end
  always_ff @(posedge clk)
    if (push) mem[wptr[AW-1:0]] <= wdata;
  assign rdata = mem[rptr[AW-1:0]];
  assign count = wptr - rptr;
  assign empty = wptr == rptr;
  assign full  = count == (AW+1)'(DEPTH);
endmodule

// File: rtl/bster_cmd_mux.sv
// bster_cmd_mux: round-robin command mux onto one core stream, with tag FIFO
// routing in-order completions back to the issuing client.
module bster_cmd_mux
  import bster_pkg::*;
#(
  parameter int NB_CHANNEL = 4,
  parameter int AXI4S_WIDTH = AXI4S_WIDTH_DEF,
  parameter int OSTD_DEPTH = 8,
  localparam int CH_W = ch_w(NB_CHANNEL)
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic [NB_CHANNEL-1:0]             s_cmd_tvalid,
  output logic [NB_CHANNEL-1:0]             s_cmd_tready,
  input  logic [NB_CHANNEL*AXI4S_WIDTH-1:0] s_cmd_tdata,
  output logic                              m_cmd_tvalid,
  input  logic                              m_cmd_tready,
  output logic [AXI4S_WIDTH-1:0]            m_cmd_tdata,
  input  logic                              s_cpl_tvalid,
  output logic                              s_cpl_tready,
  input  logic [AXI4S_WIDTH-1:0]            s_cpl_tdata,
  output logic [NB_CHANNEL-1:0]             m_cpl_tvalid,
  input  logic [NB_CHANNEL-1:0]             m_cpl_tready,
  output logic [NB_CHANNEL*AXI4S_WIDTH-1:0] m_cpl_tdata,
  output logic [$clog2(OSTD_DEPTH):0]       outstanding,
  output logic                              err_unexp_cpl
);
  logic                   slot_valid;
  logic [AXI4S_WIDTH-1:0] slot_data;
  logic [CH_W-1:0]        last_ch, g, head;
  logic                   any_valid, load_en, load, pop, tag_full, tag_empty;
  always_comb begin
    g = '0;
    any_valid = 1'b0;
    for (int k = 1; k <= NB_CHANNEL; k++)
      if (!any_valid && s_cmd_tvalid[(int'(last_ch) + k) % NB_CHANNEL]) begin
        g = CH_W'((int'(last_ch) + k) % NB_CHANNEL);
        any_valid = 1'b1;
      end
  end
  assign load_en      = aresetn & (!slot_valid | m_cmd_tready) & !tag_full;
  assign load         = load_en & any_valid;
  assign s_cmd_tready = load ? NB_CHANNEL'(1) << g : '0;
  assign m_cmd_tvalid = slot_valid;
  assign m_cmd_tdata  = slot_data;
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      slot_valid    <= 1'b0;
      slot_data     <= '0;
      last_ch       <= CH_W'(NB_CHANNEL - 1);
      err_unexp_cpl <= 1'b0;
    end else begin
      if (load) begin
        slot_valid <= 1'b1;
        slot_data  <= s_cmd_tdata[int'(g)*AXI4S_WIDTH +: AXI4S_WIDTH];
        last_ch    <= g;
      end else if (m_cmd_tready) slot_valid <= 1'b0;
      if (s_cpl_tvalid && tag_empty) err_unexp_cpl <= 1'b1;
    end
  // Completions with no outstanding tag are swallowed so the core never stalls on them.
  assign s_cpl_tready = aresetn & (tag_empty | m_cpl_tready[head]);
  assign pop          = s_cpl_tvalid & !tag_empty & m_cpl_tready[head];
  assign m_cpl_tvalid = (s_cpl_tvalid & !tag_empty) ? NB_CHANNEL'(1) << head : '0;
  assign m_cpl_tdata  = {NB_CHANNEL{s_cpl_tdata}};
  bster_tag_fifo #(.W(CH_W), .DEPTH(OSTD_DEPTH)) u_tag (
    .clk   (aclk),
    .rst_n (aresetn),
    .push  (load),
    .pop   (pop),
    .wdata (g),
    .rdata (head),
    .full  (tag_full),
    .empty (tag_empty),
    .count (outstanding)
  );
endmodule
